// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the encoder and the decoder.
// Contents: major opcode constants, the instruction-format enum, the
// canonical NOP word and a helper that maps an opcode to its format.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            OP_R:                     return FMT_R;
            OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_pack.sv
// Combinational RV32I field packer.
// Ports:
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : decoded fields
//   instr_o : packed instruction word (NOP when err_o is set)
//   err_o   : immediate/funct7/opcode cannot be encoded in the selected format
module rv32i_pack
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    fmt_e        fmt;
    logic        is_shift;
    logic [31:0] word;
    logic        bad;

    // Sign-extension range checks: every bit above the field's sign bit must
    // replicate it, i.e. the upper slice is all ones or all zeros.
    logic fits12;
    logic fits13;
    logic fits21;

    assign fits12 = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign fits13 = (&imm_i[31:12]) || !(|imm_i[31:12]);
    assign fits21 = (&imm_i[31:20]) || !(|imm_i[31:20]);

    always_comb begin
        fmt      = fmt_of(opcode_i);
        // SLLI/SRLI/SRAI: funct3 001 or 101 under OP-IMM
        is_shift = (opcode_i == OP_IMM) && (funct3_i[1:0] == 2'b01);
        word     = 32'h0;
        bad      = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                if (is_shift) begin
                    word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    bad  = (|imm_i[31:5]) ||
                           !((funct7_i == 7'b0000000) || (funct7_i == 7'b0100000));
                end else begin
                    word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    bad  = !fits12;
                end
            end
            FMT_S: begin
                word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                bad  = !fits12;
            end
            FMT_B: begin
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
                bad  = imm_i[0] || !fits13;
            end
            FMT_U: begin
                word = {imm_i[31:12], rd_i, opcode_i};
                bad  = |imm_i[11:0];
            end
            FMT_J: begin
                word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                bad  = imm_i[0] || !fits21;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        instr_o = bad ? NOP : word;
        err_o   = bad;
    end

endmodule

// File: rtl/rv32i_encode.sv
// RV32I instruction encoder: decoded fields in, addressed 32-bit words out.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   in_valid/in_ready, in_*    : field request handshake
//   out_valid/out_ready        : word handshake; out_instr, out_addr, out_err
//   addr_load, addr_value      : reload of the address counter (word aligned)
//   err_count                  : saturating count of accepted erroring words
module rv32i_encode
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    input  logic                 addr_load,
    input  logic [31:0]          addr_value,
    output logic [ERR_CNT_W-1:0] err_count
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0] pack_instr;
    logic        pack_err;

    rv32i_pack u_pack (
        .opcode_i (in_opcode),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .funct3_i (in_funct3),
        .funct7_i (in_funct7),
        .imm_i    (in_imm),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    logic                 valid_q, valid_d;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          addr_q,  addr_d;
    logic                 err_q,   err_d;
    logic [31:0]          cnt_q,   cnt_d;
    logic [ERR_CNT_W-1:0] errc_q,  errc_d;

    logic        accept;
    logic [31:0] load_addr;
    logic [31:0] word_addr;

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign load_addr = addr_value & 32'hFFFF_FFFC;
    // A load coincident with an accept addresses that very word.
    assign word_addr = addr_load ? load_addr : cnt_q;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        errc_d  = errc_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = pack_instr;
            err_d   = pack_err;
            addr_d  = word_addr;
            cnt_d   = word_addr + 32'd4;
            if (pack_err) begin
                errc_d = sat_inc(errc_q);
            end
        end else begin
            if (out_ready) begin
                valid_d = 1'b0;
            end
            if (addr_load) begin
                cnt_d = load_addr;
            end
        end
    end

    // Output register stage: input accept -> out_* one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            addr_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= BASE_ADDR;
            errc_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            errc_q  <= errc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign out_err   = err_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_rv32i_encode.sv
// Self-checking bench for rv32i_encode: directed cases with literal
// expectations, randomized field sets checked against a behavioural
// encoder model and a decoder round trip, mid-stream reset, saturation.
module tb_rv32i_encode;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          ERRMAX = 255;

    localparam logic [6:0] O_R     = 7'b0110011;
    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_IMM   = 7'b0010011;
    localparam logic [6:0] O_JALR  = 7'b1100111;
    localparam logic [6:0] O_ST    = 7'b0100011;
    localparam logic [6:0] O_BR    = 7'b1100011;
    localparam logic [6:0] O_LUI   = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_JAL   = 7'b1101111;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic [31:0] instr;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        addr_load;
    logic [31:0] addr_value;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    exp_t        q[$];
    logic [31:0] m_cnt;
    int          m_err;

    always #5 clk = ~clk;

    rv32i_encode #(.BASE_ADDR(BASE), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .err_count  (err_count)
    );

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic fields_t mk(input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
        fields_t f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
        f.f3 = f3; f.f7 = f7; f.imm = imm;
        return f;
    endfunction

    // Encoder reference: legality from signed ranges, layout from the ISA.
    function automatic logic [32:0] enc_model(input fields_t f);
        int          si;
        logic        ok;
        logic [31:0] w;
        si = $signed(f.imm);
        ok = 1'b1;
        w  = 32'h0;
        case (f.op)
            O_R: w = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
            O_LOAD, O_IMM, O_JALR: begin
                if (f.op == O_IMM && f.f3[1:0] == 2'b01) begin
                    ok = (f.imm < 32'd32) && (f.f7 == 7'h00 || f.f7 == 7'h20);
                    w  = {f.f7, f.imm[4:0], f.rs1, f.f3, f.rd, f.op};
                end else begin
                    ok = (si >= -2048) && (si <= 2047);
                    w  = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
                end
            end
            O_ST: begin
                ok = (si >= -2048) && (si <= 2047);
                w  = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
            end
            O_BR: begin
                ok = !f.imm[0] && (si >= -4096) && (si <= 4095);
                w  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
            end
            O_LUI, O_AUIPC: begin
                ok = (f.imm % 32'd4096) == 32'd0;
                w  = {f.imm[31:12], f.rd, f.op};
            end
            O_JAL: begin
                ok = !f.imm[0] && (si >= -1048576) && (si < 1048576);
                w  = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    // Decoder: recover the fields a word carries and compare to the originals.
    function automatic bit rt_ok(input fields_t f, input logic [31:0] w);
        bit ok;
        ok = (w[6:0] == f.op);
        case (f.op)
            O_R: ok &= (w[11:7] == f.rd) && (w[19:15] == f.rs1) && (w[24:20] == f.rs2) &&
                       (w[14:12] == f.f3) && (w[31:25] == f.f7);
            O_LOAD, O_IMM, O_JALR: begin
                ok &= (w[11:7] == f.rd) && (w[19:15] == f.rs1) && (w[14:12] == f.f3);
                if (f.op == O_IMM && f.f3[1:0] == 2'b01)
                    ok &= ({27'b0, w[24:20]} == f.imm) && (w[31:25] == f.f7);
                else
                    ok &= ({{20{w[31]}}, w[31:20]} == f.imm);
            end
            O_ST: ok &= (w[19:15] == f.rs1) && (w[24:20] == f.rs2) && (w[14:12] == f.f3) &&
                        ({{20{w[31]}}, w[31:25], w[11:7]} == f.imm);
            O_BR: ok &= (w[19:15] == f.rs1) && (w[24:20] == f.rs2) && (w[14:12] == f.f3) &&
                        ({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} == f.imm);
            O_LUI, O_AUIPC: ok &= (w[11:7] == f.rd) && ({w[31:12], 12'b0} == f.imm);
            O_JAL: ok &= (w[11:7] == f.rd) &&
                         ({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} == f.imm);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic fields_t rnd_fields();
        fields_t f;
        int      k;
        k     = int'($urandom_range(0, 9));
        f.rd  = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom);
        f.f7  = 7'($urandom);
        f.imm = $urandom;
        case (k)
            0, 1: f.op = O_R;
            2, 7: begin
                case ($urandom_range(0, 2))
                    0:       f.op = O_LOAD;
                    1:       f.op = O_IMM;
                    default: f.op = O_JALR;
                endcase
                if (f.op == O_IMM && f.f3[1:0] == 2'b01) begin
                    f.imm = 32'($urandom_range(0, 31));
                    f.f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end else begin
                    f.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                end
            end
            3: begin
                f.op  = O_ST;
                f.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            end
            4, 8: begin
                f.op  = O_BR;
                f.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            end
            5: begin
                f.op  = ($urandom_range(0, 1) == 1) ? O_LUI : O_AUIPC;
                f.imm = $urandom & 32'hFFFF_F000;
            end
            6: begin
                f.op  = O_JAL;
                f.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            end
            default: f.op = 7'($urandom);
        endcase
        return f;
    endfunction

    task automatic drive(input fields_t f);
        in_opcode = f.op;
        in_rd     = f.rd;
        in_rs1    = f.rs1;
        in_rs2    = f.rs2;
        in_funct3 = f.f3;
        in_funct7 = f.f7;
        in_imm    = f.imm;
    endtask

    // Present one request and return #1 after the edge that accepted it.
    task automatic send(input fields_t f, input logic ld, input logic [31:0] av,
                        output int waits);
        drive(f);
        in_valid   = 1'b1;
        addr_load  = ld;
        addr_value = av;
        waits      = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
                break;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    // Compare process: every cycle, DUT outputs against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_out_valid", 33'(out_valid), 33'd0);
            chk("rst_out_instr", 33'(out_instr), 33'd0);
            chk("rst_out_addr",  33'(out_addr),  33'd0);
            chk("rst_out_err",   33'(out_err),   33'd0);
            chk("rst_err_count", 33'(err_count), 33'd0);
            q.delete();
            m_cnt = BASE;
            m_err = 0;
        end else begin
            chk("in_ready", 33'(in_ready), 33'(!out_valid || out_ready));
            chk("out_valid", 33'(out_valid), 33'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                e = q[0];
                chk("out_instr", 33'(out_instr), 33'(e.instr));
                chk("out_err",   33'(out_err),   33'(e.err));
                chk("out_addr",  33'(out_addr),  33'(e.addr));
                if (!e.err) chk("roundtrip", 33'(rt_ok(e.f, out_instr)), 33'd1);
                if (out_ready) void'(q.pop_front());
            end
            chk("err_count", 33'(err_count), 33'(m_err));
            if (in_valid && in_ready) begin
                e.f = mk(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
                {e.err, e.instr} = enc_model(e.f);
                e.addr = addr_load ? (addr_value & 32'hFFFF_FFFC) : m_cnt;
                m_cnt  = e.addr + 32'd4;
                if (e.err && m_err < ERRMAX) m_err++;
                q.push_back(e);
            end else if (addr_load) begin
                m_cnt = addr_value & 32'hFFFF_FFFC;
            end
        end
    end

    initial begin
        int          w;
        logic [31:0] a1;
        logic [31:0] i1;
        fields_t     f;
        fields_t     addi;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        addr_load  = 1'b0;
        addr_value = 32'h0;
        addi       = mk(O_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        drive(addi);

        // Hand-computed words pin the model itself.
        chk("model_addi", enc_model(addi), {1'b0, 32'hFFF1_0093});
        chk("model_beq",  enc_model(mk(O_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8)),
            {1'b0, 32'h0020_8463});
        chk("model_jal",  enc_model(mk(O_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048)),
            {1'b0, 32'h0010_00EF});
        chk("model_lui_bad", enc_model(mk(O_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001)),
            {1'b1, 32'h0000_0013});

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 33'(in_ready), 33'd1);
        @(posedge clk);
        #1;

        send(addi, 1'b0, 32'h0, w);
        chk("addi_instr", 33'(out_instr), 33'h0_FFF1_0093);
        chk("addi_addr",  33'(out_addr),  33'(BASE));
        chk("addi_err",   33'(out_err),   33'd0);

        send(mk(O_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8), 1'b0, 32'h0, w);
        chk("beq_waits", 33'(w), 33'd0);
        chk("beq_instr", 33'(out_instr), 33'h0_0020_8463);
        chk("beq_addr",  33'(out_addr),  33'(BASE + 32'd4));
        send(mk(O_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 1'b0, 32'h0, w);
        chk("jal_waits", 33'(w), 33'd0);
        chk("jal_instr", 33'(out_instr), 33'h0_0010_00EF);
        chk("jal_addr",  33'(out_addr),  33'(BASE + 32'd8));

        send(mk(O_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3), 1'b0, 32'h0, w);
        chk("bodd_instr", 33'(out_instr), 33'h0_0000_0013);
        chk("bodd_err",   33'(out_err),   33'd1);
        send(mk(O_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001), 1'b0, 32'h0, w);
        chk("lui_instr", 33'(out_instr), 33'h0_0000_0013);
        chk("lui_err",   33'(out_err),   33'd1);
        chk("err_count_two", 33'(err_count), 33'd2);

        // Stall: one word parked, a second one waiting behind it.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(addi, 1'b0, 32'h0, w);
        a1 = out_addr;
        i1 = out_instr;
        drive(mk(O_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000));
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 33'(in_ready), 33'd0);
            chk("stall_instr",    33'(out_instr), 33'(i1));
            chk("stall_addr",     33'(out_addr),  33'(a1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_stall_addr",  33'(out_addr),  33'(a1 + 32'd4));
        chk("post_stall_instr", 33'(out_instr), 33'h0_ABCD_E1B7);

        // Address loads: coincident with accept, standalone, and wrap.
        send(addi, 1'b1, 32'h0000_1003, w);
        chk("load_addr", 33'(out_addr), 33'h0_0000_1000);
        send(addi, 1'b0, 32'h0, w);
        chk("load_next", 33'(out_addr), 33'h0_0000_1004);
        addr_load  = 1'b1;
        addr_value = 32'h0000_2002;
        @(posedge clk);
        #1;
        addr_load = 1'b0;
        send(addi, 1'b0, 32'h0, w);
        chk("idle_load_addr", 33'(out_addr), 33'h0_0000_2000);
        send(addi, 1'b1, 32'hFFFF_FFFC, w);
        chk("wrap_top", 33'(out_addr), 33'h0_FFFF_FFFC);
        send(addi, 1'b0, 32'h0, w);
        chk("wrap_zero", 33'(out_addr), 33'h0_0000_0000);

        // Randomized traffic with a reset dropped in the middle.
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                send(addi, 1'b0, 32'h0, w);
                chk("after_reset_addr", 33'(out_addr), 33'(BASE));
            end
            f = rnd_fields();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(f, ($urandom_range(0, 49) == 0), $urandom, w);
        end

        // Push the error counter into saturation.
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            send(mk(7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0, 32'h0, w);
        end
        chk("err_count_sat", 33'(err_count), 33'd255);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_encode.md
Name: rv32i_encode

Overview:
- Inverse of the instruction decoder. Accepts decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word, checks the immediate against the format's range and alignment rules, and tags each word with a sequential byte address.
- Feeds the instruction-memory loader and the self-check bench. Any word it emits, when fed back through the decoder, must reproduce the original fields.

Parameters:
- BASE_ADDR, 32'h0000_0000, address given to the first word after reset.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_opcode  in  7  major opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field (R-type, and shift-immediate upper bits).
- in_imm  in  32  immediate, sign-extended, byte units as the decoder produces it.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  32  byte address of out_instr.
- out_err  out  1  encoding error; out_instr is the canonical NOP.
- addr_load  in  1  load the address counter.
- addr_value  in  32  address to load; bits [1:0] are ignored and forced to 0.
- err_count  out  ERR_CNT_W  saturating count of emitted words with out_err=1.

Behaviour:
- Reset values:
  - out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0.
  - Internal address counter = BASE_ADDR.
  - in_ready=1 once reset is released.
- Pipeline:
  - One output register stage, so latency is 1 cycle from input accept to out_valid.
  - in_ready = !out_valid || out_ready, giving full throughput of 1 word per cycle with back-to-back handshakes.
  - While out_valid=1 && out_ready=0, all out_* signals hold stable.
- Address handling:
  - On input accept, out_addr <= counter and counter <= counter + 4. The counter wraps modulo 2^32.
  - If addr_load=1 in the same cycle as an accept, the accepted word takes addr_value[31:2]<<2 and the counter becomes that value + 4. Load wins over the current count.
  - If addr_load=1 with no accept, counter <= addr_value & ~3.
- Formats, selected by opcode:
  - R (0110011): {funct7, rs2, rs1, funct3, rd, op}.
  - I (0000011, 0010011, 1100111): {imm[11:0], rs1, funct3, rd, op}.
    - For OP-IMM shifts (op 0010011, funct3 001/101), bits [31:25]=funct7 and [24:20]=imm[4:0].
    - Error if imm[31:5] != 0.
    - Error if funct7 is not 0000000 or 0100000.
  - Other I-type: error unless imm is in the signed 12-bit range (imm[31:11] all equal).
  - S (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Same range rule as I.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
    - Error if imm[0]=1.
    - Error if the signed 13-bit range is exceeded (imm[31:12] not all equal).
  - U (0110111, 0010111): {imm[31:12], rd, op}. Error if imm[11:0] != 0.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
    - Error if imm[0]=1.
    - Error if imm[31:20] are not all equal.
  - Any other opcode is an error.
- Error handling:
  - An erroring word is still emitted and still consumes an address. out_instr=32'h0000_0013 (addi x0,x0,0) and out_err=1.
  - err_count increments when an erroring word is accepted at the input. It saturates at all-ones.
- Reset mid-operation: everything returns to reset values immediately; any in-flight word is dropped.
- Field widths are exact; no truncation warnings are allowed. Unused bits of in_imm are checked only as listed above.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants: OP_R, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL;
  - the format enum fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD};
  - the NOP constant 32'h0000_0013.
- The decoder shares the package.
- One combinational sub-module, rv32i_pack: fields in, {instr, err} out. The top module holds the handshake register, address counter and error counter.

Test Plan:
- Input: addi x1,x2,-1 (op 0010011, rd 1, rs1 2, f3 0, imm 32'hFFFF_FFFF), out_ready=1. Expect 32'hFFF1_0093, out_addr=BASE_ADDR, err=0, one cycle later.
- Input: beq x1,x2,+8, then jal x1,+2048, back to back. Expect 32'h0020_8463 then 32'h0010_00EF at addresses +0/+4, with in_ready high throughout.
- Input: B-type imm=3 (odd), then lui with imm=32'h0000_1001. Expect two NOPs with err=1 and err_count=2.
- Stall: hold out_ready=0 for 5 cycles after one word is accepted. Expect in_ready=0, out_* stable, no address advance; release and check the next word at +4.
- Input: addr_load=1 with addr_value=32'h0000_1003 coincident with an accept. Expect that word at 32'h0000_1000 and the next at 32'h0000_1004. Also check that the counter wraps from 32'hFFFF_FFFC to 0.
- Round trip: run 1000 random legal field sets through rv32i_encode and then the decoder. Expect all fields and imm to match. Assert rst_n mid-stream and expect out_valid=0 and the address back at BASE_ADDR.
